// File: rtl/pipelined_funnel_shifter_if.sv
// Request/result bundle for the pipelined funnel shifter.
// The master side issues requests and consumes results; the slave side is the shifter.
interface pipelined_funnel_shifter_if #(
  parameter int WIDTH = 8
);
  localparam int SW = $clog2(WIDTH);

  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] cin;
  logic [SW-1:0]    sh;
  logic [1:0]       mode;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] cout;

  // Status
  logic             busy;

  modport master (
    output in_valid, in, cin, sh, mode, out_ready,
    input  in_ready, out_valid, out, cout, busy
  );

  modport slave (
    input  in_valid, in, cin, sh, mode, out_ready,
    output in_ready, out_valid, out, cout, busy
  );
endinterface

// File: rtl/pipelined_funnel_shifter.sv
// Pipelined funnel shifter: a request register followed by SW log-shifter stages.
// Stage k shifts by 2^k when bit k of the shift amount is set, so every stage costs
// one mux level. Each stage tracks the fill word feeding the vacated bits and the
// carry word collecting bits pushed out of the operand, so funnel, rotate and
// arithmetic modes all reduce to the same left/right funnel step:
//   rotate-left      = funnel-left with fill = in
//   arithmetic-right = funnel-right with fill = sign of in replicated
// The whole pipeline advances together unless the output stage holds an unconsumed
// result; bubbles travel with it and are never squeezed out.
module pipelined_funnel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  pipelined_funnel_shifter_if.slave   bus
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_FUNNEL_LEFT  = 2'b00,
    MODE_FUNNEL_RIGHT = 2'b01,
    MODE_ROTATE_LEFT  = 2'b10,
    MODE_ARITH_RIGHT  = 2'b11
  } mode_e;

  // One pipeline entry. sh holds only the shift bits still to be applied: the
  // consumed bit is dropped at each stage, so every stage looks at sh[0].
  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] fill;
  } stage_t;

  // stage_q[0] is the request register, stage_q[1..SW] are the shift stages.
  stage_t        stage_q [0:SW];
  logic [SW:0]   valid_vec;
  logic          stall;
  logic          advance;

  // Only an unconsumed result at the output can hold the pipeline back.
  assign stall        = stage_q[SW].valid && !bus.out_ready;
  assign advance      = !stall;
  assign bus.in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi <= SW; gi++) begin : g_stage
      stage_t st_next;
      stage_t st_reg;

      if (gi == 0) begin : g_capture
        // Capture the request and choose the fill word that makes every mode a funnel shift.
        always_comb begin
          st_next       = '0;
          st_next.valid = bus.in_valid;
          st_next.mode  = mode_e'(bus.mode);
          st_next.sh    = bus.sh;
          st_next.data  = bus.in;
          st_next.carry = '0;
          case (mode_e'(bus.mode))
            MODE_ROTATE_LEFT: st_next.fill = bus.in;
            MODE_ARITH_RIGHT: st_next.fill = {WIDTH{bus.in[WIDTH-1]}};
            default:          st_next.fill = bus.cin;
          endcase
        end
      end else begin : g_shift
        localparam int STEP = 1 << (gi - 1);
        stage_t prev;
        assign prev = stage_q[gi-1];

        // Conditionally shift the {carry, data, fill} triple by STEP in the mode's direction.
        always_comb begin
          st_next    = prev;
          st_next.sh = prev.sh >> 1;
          if (prev.sh[0]) begin
            if (prev.mode[0] == 1'b0) begin
              // Left: data's top bits go to carry, fill's top bits enter data.
              st_next.carry = (prev.carry << STEP) | (prev.data >> (WIDTH - STEP));
              st_next.data  = (prev.data  << STEP) | (prev.fill >> (WIDTH - STEP));
              st_next.fill  = prev.fill << STEP;
            end else begin
              // Right: data's low bits go to carry, fill's low bits enter data.
              st_next.carry = (prev.carry >> STEP) | (prev.data << (WIDTH - STEP));
              st_next.data  = (prev.data  >> STEP) | (prev.fill << (WIDTH - STEP));
              st_next.fill  = prev.fill >> STEP;
            end
          end
        end
      end

      // Stage register: cleared by reset, frozen while the output is stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_reg <= '0;
        end else if (advance) begin
          st_reg <= st_next;
        end
      end

      assign stage_q[gi]   = st_reg;
      assign valid_vec[gi] = st_reg.valid;
    end
  endgenerate

  assign bus.out_valid = stage_q[SW].valid;
  assign bus.out       = stage_q[SW].data;
  assign bus.cout      = stage_q[SW].carry;
  assign bus.busy      = |valid_vec;

endmodule

// File: tb/tb_pipelined_funnel_shifter.sv
// Scoreboard bench for pipelined_funnel_shifter (WIDTH=8).
// The driver pushes the expected result of every accepted request; the monitor
// checks handshake, busy and result data against that queue each cycle.
module tb_pipelined_funnel_shifter;
  localparam int W   = 8;
  localparam int SWB = 3;

  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] co;
    int           due;   // cycle of first appearance, before adding later stalls
  } exp_t;

  logic clk;
  logic rst;
  pipelined_funnel_shifter_if #(.WIDTH(W)) bus ();

  pipelined_funnel_shifter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   total_stalls = 0;
  bit   push_pending = 0;
  exp_t q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter; an entry pushed before this edge is now inside the pipeline.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      push_pending = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Reference behaviour written straight from the mode definitions.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] c, input int s,
                                    input logic [1:0] m, output logic [W-1:0] o,
                                    output logic [W-1:0] co);
    logic [2*W-1:0] wide;
    logic [W-1:0]   co_left;
    logic [W-1:0]   co_right;
    co_left  = (s == 0) ? '0 : W'(a >> (W - s));
    co_right = (s == 0) ? '0 : W'(a << (W - s));
    wide = '0;
    case (m)
      2'b00: begin wide = {a, c} << s; o = wide[2*W-1:W]; co = co_left;  end
      2'b01: begin wide = {c, a} >> s; o = wide[W-1:0];   co = co_right; end
      2'b10: begin o = (s == 0) ? a : W'((a << s) | (a >> (W - s))); co = co_left; end
      default: begin o = W'($signed(a) >>> s); co = co_right; end
    endcase
  endfunction

  // One driver cycle; lit selects a hand-computed expectation instead of the model.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] c,
                      input logic [SWB-1:0] s, input logic [1:0] m, input logic ordy,
                      input logic lit, input logic [W-1:0] lo, input logic [W-1:0] lco);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in        = a;
    bus.cin       = c;
    bus.sh        = s;
    bus.mode      = m;
    bus.out_ready = ordy;
    #1;
    if (v && bus.in_ready) begin
      if (lit) begin
        e.o  = lo;
        e.co = lco;
      end else begin
        ref_model(a, c, int'(s), m, e.o, e.co);
      end
      e.due = cyc + 1 + SWB - total_stalls;
      q.push_back(e);
      push_pending = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 2'b00, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic rnd_req(input logic ordy);
    step(1'b1, W'($urandom), W'($urandom), SWB'($urandom), 2'($urandom), ordy, 1'b0, '0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_out"},       bus.out, 0);
    chk({tag, "_cout"},      bus.cout, 0);
    chk({tag, "_in_ready"},  bus.in_ready, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    q.delete();
    push_pending = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the scoreboard between clock edges.
  initial begin
    int   inflight;
    logic exp_valid;
    forever begin
      @(negedge clk);
      #2;
      inflight  = q.size() - int'(push_pending);
      exp_valid = (inflight > 0) && (q[0].due + total_stalls <= cyc);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("busy", bus.busy, inflight > 0);
      chk("in_ready", bus.in_ready, !(exp_valid && !bus.out_ready));
      if (exp_valid) begin
        chk("out", bus.out, q[0].o);
        chk("cout", bus.cout, q[0].co);
        if (bus.out_ready) begin
          $display("txn cycle=%0d out=%02h cout=%02h", cyc, bus.out, bus.cout);
          void'(q.pop_front());
        end else begin
          total_stalls++;
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.cin       = '0;
    bus.sh        = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    #1;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Hand-computed vectors, including sh=0 in every mode.
    step(1'b1, 8'h6B, 8'h95, 3'd2, 2'b00, 1'b1, 1'b1, 8'hAE, 8'h01);
    step(1'b1, 8'h6B, 8'h95, 3'd3, 2'b01, 1'b1, 1'b1, 8'hAD, 8'h60);
    step(1'b1, 8'h96, 8'h3C, 3'd6, 2'b10, 1'b1, 1'b1, 8'hA5, 8'h25);
    step(1'b1, 8'h96, 8'h3C, 3'd3, 2'b11, 1'b1, 1'b1, 8'hF2, 8'hC0);
    for (int m = 0; m < 4; m++)
      step(1'b1, 8'h5A, W'($urandom), 3'd0, 2'(m), 1'b1, 1'b1, 8'h5A, 8'h00);
    idle(6);

    // Back-to-back stream of 8 with the output always ready.
    for (int i = 0; i < 8; i++) rnd_req(1'b1);
    idle(6);

    // Fill the pipeline, stall the output for 4 cycles while still offering requests.
    for (int i = 0; i < 4; i++) rnd_req(1'b1);
    for (int i = 0; i < 4; i++) rnd_req(1'b0);
    for (int i = 0; i < 6; i++) rnd_req(1'b1);
    idle(6);

    // Reset with two entries in flight; nothing may come out afterwards.
    rnd_req(1'b1);
    rnd_req(1'b1);
    pulse_reset();
    idle(6);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), SWB'($urandom),
           2'($urandom), $urandom_range(0, 3) != 0, 1'b0, '0, '0);
    end
    idle(10);

    chk("drain_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_funnel_shifter.md
PIPELINED_FUNNEL_SHIFTER -- requirements
Module: pipelined_funnel_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter SW = clog2(WIDTH), derived, not overridable: shift-amount width and pipeline depth.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted on a rising edge when in_valid && in_ready.
REQ-007 in  input  WIDTH  primary operand.
REQ-008 cin  input  WIDTH  fill operand; unused in rotate and arithmetic modes.
REQ-009 sh  input  SW  shift amount, 0..WIDTH-1.
REQ-010 mode  input  2  00 funnel-left, 01 funnel-right, 10 rotate-left, 11 arithmetic-right.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  result consumed on a rising edge when out_valid && out_ready.
REQ-013 out  output  WIDTH  shifted result.
REQ-014 cout  output  WIDTH  bits shifted out of in.
REQ-015 busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-016 Mode 00: out SHALL be the upper WIDTH bits of {in,cin}<<sh; cout SHALL be in>>(WIDTH-sh), and 0 when sh=0.
REQ-017 Mode 01: out SHALL be the lower WIDTH bits of {cin,in}>>sh; cout SHALL be in<<(WIDTH-sh), and 0 when sh=0.
REQ-018 Mode 10: out SHALL be in rotated left by sh; cout SHALL be as in mode 00.
REQ-019 Mode 11: out SHALL be in shifted right by sh with in[WIDTH-1] replicated into the vacated bits; cout SHALL be as in mode 01.
REQ-020 sh=0 in any mode SHALL give out=in and cout=0.
REQ-021 Pipeline: SW registered stages; stage k SHALL apply a conditional shift by 2^k, controlled by sh bit k.
REQ-022 Each stage register SHALL carry valid, data, carry, cin, mode and the remaining sh bits.
REQ-023 Latency: a request accepted at edge N SHALL present out_valid=1 after edge N+SW, provided no stall occurs.
REQ-024 stall = out_valid && !out_ready; while stall=1, every stage SHALL hold its contents.
REQ-025 in_ready SHALL equal !stall, combinationally, with no dependence on in_valid.
REQ-026 When stall=0, a valid stage-entry SHALL advance one stage per cycle.
REQ-027 Bubbles SHALL advance with the pipeline and SHALL NOT be collapsed.
REQ-028 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-029 Results SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-030 Simultaneous acceptance and consumption in one cycle SHALL be legal.
REQ-031 out and cout SHALL be registered outputs of the final stage; when out_valid=0 their values are don't-care.
REQ-032 Inputs presented while in_ready=0 SHALL be ignored.
REQ-033 busy SHALL be the OR of all stage valid bits.

Reset
REQ-034 rst=1 SHALL immediately clear all stage valid bits, so out_valid=0 and busy=0; out, cout and all data registers SHALL go to 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight entries; none SHALL appear after release.
REQ-036 in_ready SHALL be 1 during and after reset while out_valid=0.

Verification (WIDTH=8, SW=3)
REQ-037 Mode 00, in=0x6B, cin=0x95, sh=2, out_ready=1 -> 3 cycles later out=0xAE, cout=0x01.
REQ-038 Mode 01, in=0x6B, cin=0x95, sh=3 -> out=0xAD, cout=0x60; mode 10, in=0x96, sh=6 -> out=0xA5, cout=0x25.
REQ-039 Mode 11, in=0x96, sh=3 -> out=0xF2, cout=0xC0; any mode with sh=0, in=0x5A -> out=0x5A, cout=0x00.
REQ-040 Back-to-back stream of 8 requests with out_ready=1 -> 8 consecutive out_valid cycles, in order, first result 3 cycles after the first acceptance.
REQ-041 out_ready=0 for 4 cycles with the pipeline full -> in_ready=0, out holds its first result; on release, results resume in order with no loss.
REQ-042 rst pulsed with 2 entries in flight -> out_valid=0 and busy=0 immediately; no result appears afterwards.
